// File: rtl/chua_run_ctrl.sv
// chua_run_ctrl: run controller for the fixed-point Chua iterator.
// Seeds the datapath, issues burn-in steps, then decimated steps with one
// captured sample per period, streamed out over valid/ready. The datapath is
// frozen (no dp_step) while a sample waits for the consumer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        run request (IDLE only) / cancel current run
//   num_samples, burn_in, decim, seed_x/y/z   run parameters, latched at start
//   dp_load, dp_seed_*  one-cycle seed load strobe and latched seeds
//   dp_step             datapath advance enable
//   dp_x/y/z            current datapath state
//   out_valid/ready, out_x/y/z, out_last      sample stream
//   busy, done, err     status
//
// Build option: CHUA_CTRL_OVF_GUARD_EN enables the overflow guard that ends
// the run with err=1 when dp_x leaves the representable range.
module chua_run_ctrl #(
  parameter int unsigned N     = 31,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [CNT_W-1:0] burn_in,
  input  logic [3:0]       decim,
  input  logic [N+3:0]     seed_x,
  input  logic [N+1:0]     seed_y,
  input  logic [N+3:0]     seed_z,
  output logic             dp_load,
  output logic [N+3:0]     dp_seed_x,
  output logic [N+1:0]     dp_seed_y,
  output logic [N+3:0]     dp_seed_z,
  output logic             dp_step,
  input  logic [N+3:0]     dp_x,
  input  logic [N+1:0]     dp_y,
  input  logic [N+3:0]     dp_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+3:0]     out_x,
  output logic [N+1:0]     out_y,
  output logic [N+3:0]     out_z,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BURN, S_RUN, S_CAP, S_OUT, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] num_q, num_d, burn_q, burn_d;
  logic [3:0]       decim_q, decim_d, dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] burn_cnt_q, burn_cnt_d, smp_cnt_q, smp_cnt_d;
  logic [N+3:0]     seed_x_q, seed_x_d, seed_z_q, seed_z_d;
  logic [N+1:0]     seed_y_q, seed_y_d;

  logic             dp_load_q, dp_load_d, dp_step_q, dp_step_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [N+3:0]     out_x_q, out_x_d, out_z_q, out_z_d;
  logic [N+1:0]     out_y_q, out_y_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Range check: the two top bits of x disagree once the state overflows.
  logic ovf_c;
`ifdef CHUA_CTRL_OVF_GUARD_EN
  logic err_q, err_d;
  assign ovf_c = dp_x[N+3] != dp_x[N+2];
  assign err   = err_q;
`else
  assign ovf_c = 1'b0;
  assign err   = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      burn_q      <= '0;
      decim_q     <= '0;
      dec_cnt_q   <= '0;
      burn_cnt_q  <= '0;
      smp_cnt_q   <= '0;
      seed_x_q    <= '0;
      seed_y_q    <= '0;
      seed_z_q    <= '0;
      dp_load_q   <= 1'b0;
      dp_step_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CHUA_CTRL_OVF_GUARD_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      burn_q      <= burn_d;
      decim_q     <= decim_d;
      dec_cnt_q   <= dec_cnt_d;
      burn_cnt_q  <= burn_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      seed_x_q    <= seed_x_d;
      seed_y_q    <= seed_y_d;
      seed_z_q    <= seed_z_d;
      dp_load_q   <= dp_load_d;
      dp_step_q   <= dp_step_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CHUA_CTRL_OVF_GUARD_EN
      err_q       <= err_d;
`endif
    end
  end

  // Next state, parameter latches and run counters.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    burn_d     = burn_q;
    decim_d    = decim_q;
    dec_cnt_d  = dec_cnt_q;
    burn_cnt_d = burn_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    seed_x_d   = seed_x_q;
    seed_y_d   = seed_y_q;
    seed_z_d   = seed_z_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d      = num_samples;
          burn_d     = burn_in;
          decim_d    = (decim == 4'd0) ? 4'd1 : decim;
          seed_x_d   = seed_x;
          seed_y_d   = seed_y;
          seed_z_d   = seed_z;
          dec_cnt_d  = '0;
          burn_cnt_d = '0;
          smp_cnt_d  = '0;
          state_d    = (num_samples == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: state_d = (burn_q != '0) ? S_BURN : S_RUN;
      S_BURN: begin
        if (ovf_c) begin
          state_d = S_DONE;
        end else if (burn_cnt_q == burn_q - CNT_ONE) begin
          state_d = S_RUN;
        end else begin
          burn_cnt_d = burn_cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (ovf_c) begin
          state_d = S_DONE;
        end else if (dec_cnt_q == decim_q - 4'd1) begin
          dec_cnt_d = '0;
          state_d   = S_CAP;
        end else begin
          dec_cnt_d = dec_cnt_q + 4'd1;
        end
      end
      S_CAP: state_d = ovf_c ? S_DONE : S_OUT;
      S_OUT: begin
        if (out_ready) begin
          smp_cnt_d = smp_cnt_q + CNT_ONE;
          state_d   = out_last_q ? S_DONE : S_RUN;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks every other transition, including the handshake.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_comb begin
    dp_load_d   = (state_d == S_LOAD);
    dp_step_d   = (state_d == S_BURN) || (state_d == S_RUN);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    out_last_d  = out_last_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_z_d     = out_z_q;
    if ((state_q == S_CAP) && (state_d == S_OUT)) begin
      out_x_d    = dp_x;
      out_y_d    = dp_y;
      out_z_d    = dp_z;
      out_last_d = (smp_cnt_q == num_q - CNT_ONE);
    end
`ifdef CHUA_CTRL_OVF_GUARD_EN
    err_d = err_q;
    if ((state_q == S_IDLE) && start) begin
      err_d = 1'b0;
    end
    // Only the guard moves a stepping state straight to DONE.
    if (((state_q == S_BURN) || (state_q == S_RUN) || (state_q == S_CAP)) &&
        (state_d == S_DONE)) begin
      err_d = 1'b1;
    end
`endif
  end

  assign dp_load   = dp_load_q;
  assign dp_step   = dp_step_q;
  assign dp_seed_x = seed_x_q;
  assign dp_seed_y = seed_y_q;
  assign dp_seed_z = seed_z_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
